// File: rtl/vmem_local_seq.sv
// Banked local vector memory: unit/strided(/indexed) vector loads and stores on port A, independent per-lane port B.
// Define VMEM_LOCAL_SEQ_INDEXED_EN to build indexed addressing; otherwise indexed requests complete as empty operations.

module per_lane_mem_wrapper #(
    parameter int DATAWORDSIZE = 16,
    parameter int MEMDEPTH     = 2048,
    parameter int LOGMEMDEPTH  = $clog2(MEMDEPTH)
) (
    input  logic                    clk,
    input  logic                    wren_a,
    input  logic                    rden_a,
    input  logic [LOGMEMDEPTH-1:0]  address_a,
    input  logic [DATAWORDSIZE-1:0] data_a,
    output logic [DATAWORDSIZE-1:0] q_a,
    input  logic                    wren_b,
    input  logic                    rden_b,
    input  logic [LOGMEMDEPTH-1:0]  address_b,
    input  logic [DATAWORDSIZE-1:0] data_b,
    output logic [DATAWORDSIZE-1:0] q_b
);
    logic [DATAWORDSIZE-1:0] mem [MEMDEPTH];

    always_ff @(posedge clk) begin
        if (wren_a) mem[address_a] <= data_a;
        if (wren_b) mem[address_b] <= data_b;
        if (rden_a) q_a <= mem[address_a];
        if (rden_b) q_b <= mem[address_b];
    end
endmodule

module vmem_local_seq #(
    parameter int NUMLANES     = 8,
    parameter int DATAWORDSIZE = 16,
    parameter int VCWIDTH      = 32,
    parameter int MEMDEPTH     = 2048,
    parameter int LOGMEMDEPTH  = $clog2(MEMDEPTH),
    parameter int MAXVL        = 64,
    parameter int VLW          = $clog2(MAXVL + 1)
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [6:0]                       req_op,
    input  logic [LOGMEMDEPTH-1:0]           req_base,
    input  logic [VCWIDTH-1:0]               req_stride,
    input  logic [VLW-1:0]                   req_vl,
    input  logic                             beat_valid,
    output logic                             beat_ready,
    input  logic [NUMLANES*DATAWORDSIZE-1:0] beat_data,
    input  logic [NUMLANES*16-1:0]           beat_offset,
    output logic                             rd_valid,
    output logic                             rd_last,
    output logic [NUMLANES*DATAWORDSIZE-1:0] rd_data,
    output logic [NUMLANES-1:0]              rd_mask,
    output logic                             busy,
    output logic                             done,
    input  logic [NUMLANES*LOGMEMDEPTH-1:0]  address_b,
    input  logic                             rden_b,
    input  logic                             wren_b,
    input  logic [NUMLANES*DATAWORDSIZE-1:0] data_b,
    output logic [NUMLANES*DATAWORDSIZE-1:0] out_b,
    output logic                             collision
);
    localparam logic [1:0] PAT_STRIDED = 2'd1;
    localparam logic [1:0] PAT_INDEXED = 2'd2;
    localparam logic [1:0] PAT_RSVD    = 2'd3;
`ifdef VMEM_LOCAL_SEQ_INDEXED_EN
    localparam bit INDEXED_EN = 1'b1;
`else
    localparam bit INDEXED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [6:0]                            op_q;
    logic [VLW-1:0]                        vl_q, k_q;
    logic [LOGMEMDEPTH-1:0]                base_q;
    logic [VCWIDTH-1:0]                    stride_q;
    logic                                  is_store, is_idx, need_beat;
    logic                                  accept, req_noop, issue, last_beat;
    logic [VCWIDTH-1:0]                    stride_eff, beat_base, next_base;
    logic [NUMLANES-1:0]                   active, wren_a, rden_a, clash;
    logic [NUMLANES-1:0][VCWIDTH-1:0]      addr_full;
    logic [NUMLANES-1:0][DATAWORDSIZE-1:0] q_a;
    logic                                  vld_p1, last_p1;
    logic [NUMLANES-1:0]                   mask_p1;

    assign is_store   = op_q[0];
    assign is_idx     = INDEXED_EN && (op_q[5:4] == PAT_INDEXED);
    assign need_beat  = is_store || is_idx;
    assign stride_eff = (op_q[5:4] == PAT_STRIDED) ? stride_q : VCWIDTH'(1);
    assign beat_base  = VCWIDTH'(k_q) * VCWIDTH'(NUMLANES);
    assign next_base  = beat_base + VCWIDTH'(NUMLANES);
    assign last_beat  = next_base >= VCWIDTH'(vl_q);

    // Requests that would touch no element skip straight to the completion pulse.
    assign accept   = req_valid && (state == IDLE);
    assign req_noop = !req_op[6] || (req_vl == '0) || (req_op[5:4] == PAT_RSVD) ||
                      (!INDEXED_EN && (req_op[5:4] == PAT_INDEXED));

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            IDLE: if (accept) state_nx = req_noop ? DRAIN : RUN;
            RUN: begin
                issue = need_beat ? beat_valid : 1'b1;
                if (issue && last_beat) state_nx = DRAIN;
            end
            DRAIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = (state == DRAIN);
    assign beat_ready = (state == RUN) && need_beat;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            k_q     <= '0;
            op_q    <= '0;
            vl_q    <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            mask_p1 <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q <= req_op;
                vl_q <= req_vl;
                k_q  <= '0;
            end else if (issue) begin
                k_q <= k_q + VLW'(1);
            end
            // p1: load beat read from the banks, returned next cycle
            vld_p1  <= issue && !is_store;
            last_p1 <= issue && !is_store && last_beat;
            mask_p1 <= (issue && !is_store) ? active : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            base_q   <= req_base;
            stride_q <= req_stride;
        end
    end

    for (genvar i = 0; i < NUMLANES; i++) begin : g_lane
        logic [VCWIDTH-1:0]     eidx, lin_addr;
        logic [LOGMEMDEPTH-1:0] addr_a, addr_b_l;

        assign eidx      = beat_base + VCWIDTH'(i);
        assign active[i] = eidx < VCWIDTH'(vl_q);
        assign lin_addr  = VCWIDTH'(base_q) + eidx * stride_eff;
`ifdef VMEM_LOCAL_SEQ_INDEXED_EN
        logic [VCWIDTH-1:0] idx_addr;
        assign idx_addr     = VCWIDTH'(base_q) + VCWIDTH'(beat_offset[i*16 +: 16]);
        assign addr_full[i] = is_idx ? idx_addr : lin_addr;
`else
        assign addr_full[i] = lin_addr;
`endif
        // Addresses wrap modulo MEMDEPTH by truncation.
        assign addr_a    = addr_full[i][LOGMEMDEPTH-1:0];
        assign addr_b_l  = address_b[i*LOGMEMDEPTH +: LOGMEMDEPTH];
        assign wren_a[i] = issue && is_store && active[i];
        assign rden_a[i] = issue && !is_store && active[i];
        assign clash[i]  = wren_a[i] && wren_b && (addr_a == addr_b_l);

        per_lane_mem_wrapper #(
            .DATAWORDSIZE(DATAWORDSIZE),
            .MEMDEPTH    (MEMDEPTH),
            .LOGMEMDEPTH (LOGMEMDEPTH)
        ) u_mem (
            .clk      (clk),
            .wren_a   (wren_a[i]),
            .rden_a   (rden_a[i]),
            .address_a(addr_a),
            .data_a   (beat_data[i*DATAWORDSIZE +: DATAWORDSIZE]),
            .q_a      (q_a[i]),
            .wren_b   (wren_b && !clash[i]),
            .rden_b   (rden_b),
            .address_b(addr_b_l),
            .data_b   (data_b[i*DATAWORDSIZE +: DATAWORDSIZE]),
            .q_b      (out_b[i*DATAWORDSIZE +: DATAWORDSIZE])
        );

        assign rd_data[i*DATAWORDSIZE +: DATAWORDSIZE] = mask_p1[i] ? q_a[i] : '0;
    end

    assign collision = |clash;
    assign rd_valid  = vld_p1;
    assign rd_last   = last_p1;
    assign rd_mask   = mask_p1;

    // Element size/sign fields and the high address bits above the bank depth carry no function here.
    logic unused_bits;
`ifdef VMEM_LOCAL_SEQ_INDEXED_EN
    assign unused_bits = ^{op_q[3:1], addr_full};
`else
    assign unused_bits = ^{op_q[3:1], addr_full, beat_offset};
`endif
endmodule

// File: tb/tb_vmem_local_seq.sv
// Directed self-checking bench for vmem_local_seq: vector table of loads plus hand sequences for corner cases.
module tb_vmem_local_seq;
    localparam int NL = 8, DW = 16, LD = 11, VLW = 7;

    logic              clk = 1'b0, resetn = 1'b0;
    logic              req_valid = 1'b0, req_ready;
    logic [6:0]        req_op = '0;
    logic [LD-1:0]     req_base = '0;
    logic [31:0]       req_stride = '0;
    logic [VLW-1:0]    req_vl = '0;
    logic              beat_valid = 1'b0, beat_ready;
    logic [NL*DW-1:0]  beat_data = '0;
    logic [NL*16-1:0]  beat_offset = '0;
    logic              rd_valid, rd_last, busy, done, collision;
    logic [NL*DW-1:0]  rd_data, out_b;
    logic [NL-1:0]     rd_mask;
    logic [NL*LD-1:0]  address_b = '0;
    logic              rden_b = 1'b0, wren_b = 1'b0;
    logic [NL*DW-1:0]  data_b = '0;

    always #5 clk = ~clk;

    vmem_local_seq dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_base(req_base), .req_stride(req_stride), .req_vl(req_vl),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_data(beat_data), .beat_offset(beat_offset),
        .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data), .rd_mask(rd_mask),
        .busy(busy), .done(done),
        .address_b(address_b), .rden_b(rden_b), .wren_b(wren_b),
        .data_b(data_b), .out_b(out_b), .collision(collision)
    );

    typedef struct {
        logic [6:0]  op;
        int          base;
        int          stride;
        int          vl;
        int          beats;
        logic [7:0]  last_mask;
        int          probe_k;
        int          probe_lane;
        logic [15:0] probe_val;
    } vec_t;

    vec_t        tbl[8];
    int          n_tests = 0, n_fail = 0;
    logic [127:0] cap_data[16];
    logic [7:0]  cap_mask[16];
    logic        cap_last[16];
    int          cap_cyc[16];
    int          ncap, done_cyc;

    function automatic logic [15:0] fill(input int lane, input int addr);
        return 16'(addr * 8 + lane);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outs(input string name);
        check({name, "_ctl"}, {req_ready, busy, done, rd_valid, rd_last, beat_ready, collision}, 7'b1000000);
        check({name, "_mask"}, rd_mask, 0);
        check({name, "_data"}, rd_data, 0);
    endtask

    task automatic run_op(input logic [6:0] op, input int base, input int stride, input int vl,
                          input int delay, input int stval);
        int  k, cyc;
        bit  need;
        need = op[0] || (op[5:4] == 2'd2);
        ncap = 0;
        done_cyc = -1;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_base = LD'(base);
        req_stride = 32'(stride); req_vl = VLW'(vl);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        cyc = 0;
        while (done_cyc < 0 && cyc < 200) begin
            if (rd_valid && ncap < 16) begin
                cap_data[ncap] = rd_data; cap_mask[ncap] = rd_mask;
                cap_last[ncap] = rd_last; cap_cyc[ncap] = cyc;
                ncap++;
            end
            if (done) done_cyc = cyc;
            beat_valid = 1'b0;
            if (need && cyc >= delay) begin
                beat_valid = 1'b1;
                for (int i = 0; i < NL; i++) begin
                    beat_data[i*16 +: 16]   = 16'(stval + k * 8 + i);
                    beat_offset[i*16 +: 16] = 16'(5 * i + 40 * k);
                end
                if (beat_ready) k++;
            end
            @(negedge clk);
            cyc++;
        end
        beat_valid = 1'b0;
        if (done_cyc < 0) begin
            n_tests++; n_fail++;
            $display("FAIL op_timeout: no done within 200 cycles, op=%0h", op);
        end
    endtask

    task automatic check_model(input string name, input logic [6:0] op, input int base,
                               input int stride, input int vl, input int beats);
        int          errs, es, e, addr;
        logic        exp_m;
        logic [15:0] expd;
        errs = 0;
        es = (op[5:4] == 2'd1) ? stride : 1;
        for (int j = 0; j < ncap; j++) begin
            for (int i = 0; i < NL; i++) begin
                e = j * 8 + i;
                exp_m = (e < vl);
                if (cap_mask[j][i] !== exp_m) errs++;
                addr = (base + e * es) % 2048;
                expd = exp_m ? fill(i, addr) : 16'h0;
                if (cap_data[j][i*16 +: 16] !== expd) errs++;
            end
            if (cap_last[j] !== (j == beats - 1)) errs++;
        end
        check({name, "_model_errs"}, errs, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        string       nm;
        logic [7:0]  lm;
        logic [15:0] pv;
        int          dseen;

        tbl[0] = '{7'h40, 0,    1,   64, 8, 8'hFF, 7, 7, 16'd511};
        tbl[1] = '{7'h50, 4,    3,   11, 2, 8'h07, 1, 2, 16'd274};
        tbl[2] = '{7'h40, 2046, 1,   4,  1, 8'h0F, 0, 3, 16'd11};
        tbl[3] = '{7'h40, 100,  5,   20, 3, 8'h0F, 2, 3, 16'd955};
        tbl[4] = '{7'h50, 5,    300, 9,  2, 8'h01, 1, 0, 16'd2856};
        tbl[5] = '{7'h50, 7,    0,   3,  1, 8'h07, 0, 2, 16'd58};
        tbl[6] = '{7'h40, 0,    1,   0,  0, 8'h00, 0, 0, 16'd0};
        tbl[7] = '{7'h00, 0,    1,   8,  0, 8'h00, 0, 0, 16'd0};

        repeat (2) @(negedge clk);
        check_reset_outs("reset");
        resetn = 1'b1;

        for (int a = 0; a < 2048; a++) begin
            wren_b = 1'b1;
            for (int i = 0; i < NL; i++) begin
                address_b[i*LD +: LD] = LD'(a);
                data_b[i*16 +: 16]    = fill(i, a);
            end
            @(negedge clk);
        end
        wren_b = 1'b0;

        for (int n = 0; n < 8; n++) begin
            v  = tbl[n];
            nm = $sformatf("vec%0d", n);
            run_op(v.op, v.base, v.stride, v.vl, 0, 0);
            check({nm, "_beats"}, ncap, v.beats);
            check({nm, "_done_cyc"}, done_cyc, v.beats);
            if (v.beats > 0) begin
                check({nm, "_first_rd_cyc"}, cap_cyc[0], 1);
                lm = (ncap > 0) ? cap_mask[ncap-1] : 8'h00;
                check({nm, "_last_mask"}, lm, v.last_mask);
                pv = (v.probe_k < ncap) ? cap_data[v.probe_k][v.probe_lane*16 +: 16] : 16'h0;
                check({nm, "_probe"}, pv, v.probe_val);
            end
            check_model(nm, v.op, v.base, v.stride, v.vl, v.beats);
        end

        // Unit store then unit load at base 0
        run_op(7'h41, 0, 1, 8, 0, 0);
        check("st0_beats", ncap, 0);
        check("st0_done_cyc", done_cyc, 1);
        run_op(7'h40, 0, 1, 8, 0, 0);
        check("ld0_beats", ncap, 1);
        check("ld0_data", cap_data[0], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        check("ld0_mask_last", {cap_mask[0], cap_last[0]}, {8'hFF, 1'b1});
        check("ld0_done_cyc", done_cyc, 1);

        // Partial store leaves inactive lanes untouched
        run_op(7'h41, 200, 1, 3, 0, 256);
        run_op(7'h40, 200, 1, 8, 0, 0);
        check("pst_active", cap_data[0][47:0], 48'h0102_0101_0100);
        check("pst_lane3", cap_data[0][63:48], 16'd1627);
        check("pst_lane7", cap_data[0][127:112], 16'd1663);

        // Indexed load with beat_valid stalled for 3 cycles
        run_op(7'h60, 100, 0, 8, 3, 0);
`ifdef VMEM_LOCAL_SEQ_INDEXED_EN
        check("idx_beats", ncap, 1);
        check("idx_rd_cyc", cap_cyc[0], 4);
        check("idx_lane1", cap_data[0][31:16], 16'd841);
        check("idx_lane7", cap_data[0][127:112], 16'd1087);
        check("idx_done_cyc", done_cyc, 4);
`else
        check("idx_off_beats", ncap, 0);
        check("idx_off_done_cyc", done_cyc, 0);
`endif

        // Port A store and port B write on lane 0, address 10, same cycle
        @(negedge clk);
        req_valid = 1'b1; req_op = 7'h41; req_base = 11'd10; req_vl = 7'd1;
        @(negedge clk);
        req_valid = 1'b0;
        beat_valid = 1'b1;
        beat_data = '0;
        beat_data[15:0] = 16'hAAAA;
        wren_b = 1'b1;
        for (int i = 0; i < NL; i++) begin
            address_b[i*LD +: LD] = 11'd10;
            data_b[i*16 +: 16]    = 16'h1234;
        end
        data_b[15:0] = 16'h5555;
        #1;
        check("coll_pulse", collision, 1);
        check("coll_bready", beat_ready, 1);
        @(negedge clk);
        beat_valid = 1'b0;
        address_b[10:0] = 11'd11;
        #1;
        check("coll_clear", collision, 0);
        check("coll_done", done, 1);
        @(negedge clk);
        wren_b = 1'b0;
        rden_b = 1'b1;
        address_b[10:0] = 11'd10;
        @(negedge clk);
        rden_b = 1'b0;
        check("coll_a_wins", out_b[15:0], 16'hAAAA);
        check("coll_b_lane1", out_b[31:16], 16'h1234);

        // Reset in the middle of a vl=64 load
        @(negedge clk);
        req_valid = 1'b1; req_op = 7'h40; req_base = '0; req_vl = 7'd64;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pre_busy_valid", {busy, rd_valid}, 2'b11);
        #2 resetn = 1'b0;
        #1 check_reset_outs("rst_mid");
        dseen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dseen++;
        end
        check("rst_no_done", dseen, 0);
        resetn = 1'b1;
        #1 check("rst_ready", req_ready, 1);
        run_op(7'h40, 0, 1, 8, 0, 0);
        check("rst_after_beats", ncap, 1);
        check("rst_after_data", cap_data[0], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        check("rst_after_done_cyc", done_cyc, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
